// File: rtl/ras_bram_vfwd.sv
// ras_bram_vfwd: dual-port RAS storage BRAM with per-entry valid, single-cycle flush, collision forwarding, 1/2-cycle read latency; RAS_BRAM_PARITY_EN adds per-entry even parity and perra/perrb
module ras_bram_vfwd #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 36,
  parameter int READ_LATENCY = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rea,
  input  logic             wea,
  input  logic [AW-1:0]    raddra,
  input  logic [AW-1:0]    waddra,
  input  logic [WIDTH-1:0] wia,
  input  logic             reb,
  input  logic             web,
  input  logic [AW-1:0]    raddrb,
  input  logic [AW-1:0]    waddrb,
  input  logic [WIDTH-1:0] wib,
  output logic [WIDTH-1:0] doa,
  output logic             vlda,
  output logic [WIDTH-1:0] dob,
  output logic             vldb
`ifdef RAS_BRAM_PARITY_EN
  ,
  output logic             perra,
  output logic             perrb
`endif
);
`ifdef RAS_BRAM_PARITY_EN
  localparam int SW = WIDTH + 2;
  logic par_mem [DEPTH];
`else
  localparam int SW = WIDTH + 1;
`endif
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] addr_a, addr_b;
  logic in_a, in_b, act_a, act_b, wr_a, wr_b, col, rv_a, rv_b;
  logic [SW-1:0] oa_d, oa_q, ob_d, ob_q, fa, fb;
  always_comb begin
    addr_a = wea ? waddra : raddra;
    addr_b = web ? waddrb : raddrb;
    in_a = int'(addr_a) < DEPTH;
    in_b = int'(addr_b) < DEPTH;
    act_a = rea | wea;
    act_b = reb | web;
    wr_a = wea & in_a;
    wr_b = web & in_b;
    col = act_a & act_b & in_a & in_b & (addr_a == addr_b);
    rv_a = in_a & valid_q[addr_a];
    rv_b = in_b & valid_q[addr_b];
    oa_d = oa_q;
    ob_d = ob_q;
    if (act_a) oa_d[WIDTH:0] = (col & web) ? {1'b1, wib} : wea ? {wr_a, wr_a ? wia : WIDTH'(0)} : {rv_a, rv_a ? mem[addr_a] : WIDTH'(0)};
    if (act_b) ob_d[WIDTH:0] = web ? {wr_b, wr_b ? wib : WIDTH'(0)} : (col & wea) ? {1'b1, wia} : {rv_b, rv_b ? mem[addr_b] : WIDTH'(0)};
`ifdef RAS_BRAM_PARITY_EN
    if (act_a) oa_d[SW-1] = ~wea & ~(col & web) & rv_a & ((^mem[addr_a]) != par_mem[addr_a]);
    if (act_b) ob_d[SW-1] = ~web & ~(col & wea) & rv_b & ((^mem[addr_b]) != par_mem[addr_b]);
`endif
    valid_d = flush ? '0 : valid_q;
    if (wr_a) valid_d[addr_a] = 1'b1;
    if (wr_b) valid_d[addr_b] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wr_a) mem[addr_a] <= wia;
    if (wr_b) mem[addr_b] <= wib;
`ifdef RAS_BRAM_PARITY_EN
    if (wr_a) par_mem[addr_a] <= ^wia;
    if (wr_b) par_mem[addr_b] <= ^wib;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      oa_q <= '0;
      ob_q <= '0;
    end else begin
      valid_q <= valid_d;
      oa_q <= oa_d;
      ob_q <= ob_d;
    end
  end
  if (READ_LATENCY == 2) begin : g_l2
    logic [SW-1:0] oa2_q, ob2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        oa2_q <= '0;
        ob2_q <= '0;
      end else begin
        oa2_q <= oa_q;
        ob2_q <= ob_q;
      end
    end
    assign fa = oa2_q;
    assign fb = ob2_q;
  end else if (READ_LATENCY == 1) begin : g_l1
    assign fa = oa_q;
    assign fb = ob_q;
  end else begin : g_bad
    $error("READ_LATENCY must be 1 or 2");
  end
  assign {vlda, doa} = fa[WIDTH:0];
  assign {vldb, dob} = fb[WIDTH:0];
`ifdef RAS_BRAM_PARITY_EN
  assign perra = fa[SW-1];
  assign perrb = fb[SW-1];
`endif
endmodule

// File: tb/tb_ras_bram_vfwd.sv
// tb_ras_bram_vfwd: scoreboard bench for ras_bram_vfwd at read latency 1 and 2 against a spec-level reference model
module tb_ras_bram_vfwd;
  localparam int DEPTH = 1024;
  localparam int WIDTH = 36;
  localparam int AW = 10;
  typedef struct { int due; logic [WIDTH:0] e; } ent_t;
  typedef struct { int due; logic b; logic [WIDTH:0] e; } dir_t;
  logic clk = 0, rst_n = 0, flush = 0, rea = 0, wea = 0, reb = 0, web = 0;
  logic [AW-1:0] raddra = 0, waddra = 0, raddrb = 0, waddrb = 0;
  logic [WIDTH-1:0] wia = 0, wib = 0;
  logic [WIDTH-1:0] doa1, dob1, doa2, dob2;
  logic vlda1, vldb1, vlda2, vldb2;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic mon_en = 0;
  ent_t qa1[$], qb1[$], qa2[$], qb2[$];
  dir_t dq[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit m_val [DEPTH];
  logic [WIDTH:0] la = '0, lb = '0;
  logic [63:0] t64;
  ras_bram_vfwd #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rea(rea), .wea(wea), .raddra(raddra), .waddra(waddra), .wia(wia),
    .reb(reb), .web(web), .raddrb(raddrb), .waddrb(waddrb), .wib(wib),
    .doa(doa1), .vlda(vlda1), .dob(dob1), .vldb(vldb1)
  );
  ras_bram_vfwd #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rea(rea), .wea(wea), .raddra(raddra), .waddra(waddra), .wia(wia),
    .reb(reb), .web(web), .raddrb(raddrb), .waddrb(waddrb), .wib(wib),
    .doa(doa2), .vlda(vlda2), .dob(dob2), .vldb(vldb2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc %0d: got vld=%0b d=%h, expected vld=%0b d=%h", name, cyc, got[WIDTH], got[WIDTH-1:0], exp[WIDTH], exp[WIDTH-1:0]);
  endtask
  always @(negedge clk) begin
    ent_t t;
    dir_t u;
    cyc++;
    if (mon_en) begin
      while (qa1.size() > 0 && qa1[0].due <= cyc) begin t = qa1.pop_front(); chk("a_l1", {vlda1, doa1}, t.e); end
      while (qb1.size() > 0 && qb1[0].due <= cyc) begin t = qb1.pop_front(); chk("b_l1", {vldb1, dob1}, t.e); end
      while (qa2.size() > 0 && qa2[0].due <= cyc) begin t = qa2.pop_front(); chk("a_l2", {vlda2, doa2}, t.e); end
      while (qb2.size() > 0 && qb2[0].due <= cyc) begin t = qb2.pop_front(); chk("b_l2", {vldb2, dob2}, t.e); end
      while (dq.size() > 0 && dq[0].due <= cyc) begin
        u = dq.pop_front();
        chk(u.b ? "dir_b" : "dir_a", u.b ? {vldb1, dob1} : {vlda1, doa1}, u.e);
      end
    end
  end
  function automatic logic [WIDTH-1:0] post(input logic [AW-1:0] x);
    return (web && waddrb == x) ? wib : (wea && waddra == x) ? wia : m_mem[x];
  endfunction
  task automatic issue();
    logic [AW-1:0] aa, ab;
    aa = wea ? waddra : raddra;
    ab = web ? waddrb : raddrb;
    if (rea || wea) la = (wea || (web && ab == aa)) ? {1'b1, post(aa)} : m_val[aa] ? {1'b1, m_mem[aa]} : '0;
    if (reb || web) lb = (web || (wea && aa == ab)) ? {1'b1, post(ab)} : m_val[ab] ? {1'b1, m_mem[ab]} : '0;
    qa1.push_back('{cyc + 1, la});
    qb1.push_back('{cyc + 1, lb});
    qa2.push_back('{cyc + 2, la});
    qb2.push_back('{cyc + 2, lb});
    if (flush) foreach (m_val[i]) m_val[i] = 0;
    if (wea) begin m_mem[waddra] = wia; m_val[waddra] = 1; end
    if (web) begin m_mem[waddrb] = wib; m_val[waddrb] = 1; end
  endtask
  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? AW'(1016 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
  endfunction
  task automatic step(input logic f, input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [WIDTH-1:0] da,
                      input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [WIDTH-1:0] db);
    @(negedge clk);
    #1;
    flush = f; rea = ra; wea = wa; wia = da; reb = rb; web = wb; wib = db;
    raddra = wa ? rnd_addr() : aa; waddra = wa ? aa : rnd_addr();
    raddrb = wb ? rnd_addr() : ab; waddrb = wb ? ab : rnd_addr();
    issue();
  endtask
  task automatic exp_dir(input logic b, input logic [WIDTH:0] e);
    dq.push_back('{cyc + 1, b, e});
  endtask
  initial begin
    #2;
    chk("rst_a1", {vlda1, doa1}, '0);
    chk("rst_b1", {vldb1, dob1}, '0);
    chk("rst_a2", {vlda2, doa2}, '0);
    chk("rst_b2", {vldb2, dob2}, '0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;
    mon_en = 1;
    step(0, 1, 0, 5, 0, 0, 0, 0, 0); exp_dir(0, '0);
    step(0, 0, 1, 5, 36'h123456789, 0, 0, 0, 0); exp_dir(0, {1'b1, 36'h123456789});
    step(0, 0, 0, 0, 0, 1, 0, 5, 0); exp_dir(1, {1'b1, 36'h123456789});
    step(0, 0, 1, 7, 36'hAAA, 0, 1, 7, 36'hBBB); exp_dir(0, {1'b1, 36'hBBB}); exp_dir(1, {1'b1, 36'hBBB});
    step(0, 1, 0, 7, 0, 0, 0, 0, 0); exp_dir(0, {1'b1, 36'hBBB});
    step(0, 0, 1, 3, 36'h55, 1, 0, 3, 0); exp_dir(1, {1'b1, 36'h55});
    step(0, 1, 0, 3, 0, 0, 1, 3, 36'h66); exp_dir(0, {1'b1, 36'h66});
    for (int i = 0; i < 4; i++) step(0, 0, 1, AW'(i), WIDTH'(256 + i), 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 1, 2, 36'h9); exp_dir(0, {1'b1, WIDTH'(257)}); exp_dir(1, {1'b1, 36'h9});
    step(0, 1, 0, 1, 0, 1, 0, 2, 0); exp_dir(0, '0); exp_dir(1, {1'b1, 36'h9});
    repeat (400) begin
      @(negedge clk);
      #1;
      flush = ($urandom_range(0, 15) == 0);
      rea = 1'($urandom_range(0, 1));
      wea = ($urandom_range(0, 2) == 0);
      reb = 1'($urandom_range(0, 1));
      web = ($urandom_range(0, 2) == 0);
      raddra = rnd_addr(); waddra = rnd_addr(); raddrb = rnd_addr(); waddrb = rnd_addr();
      t64 = {$urandom, $urandom}; wia = t64[WIDTH-1:0];
      t64 = {$urandom, $urandom}; wib = t64[WIDTH-1:0];
      issue();
    end
    step(0, 0, 1, 20, 36'hDEAD, 0, 0, 0, 0);
    step(0, 0, 1, 21, 36'hBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    mon_en = 0;
    flush = 0; wea = 0; reb = 0; web = 0; rea = 1; raddra = 20;
    @(posedge clk);
    #2;
    chk("rst_pre_l1", {vlda1, doa1}, {1'b1, 36'hDEAD});
    chk("rst_pre_l2", {vlda2, doa2}, {1'b1, 36'hBEEF});
    rst_n = 0;
    #1;
    chk("rst_async_a1", {vlda1, doa1}, '0);
    chk("rst_async_b1", {vldb1, dob1}, '0);
    chk("rst_async_a2", {vlda2, doa2}, '0);
    chk("rst_async_b2", {vldb2, dob2}, '0);
    rea = 0;
    @(posedge clk);
    #1;
    chk("rst_lost_l2", {vlda2, doa2}, '0);
    @(negedge clk);
    #1;
    rst_n = 1;
    foreach (m_val[i]) m_val[i] = 0;
    la = '0;
    lb = '0;
    mon_en = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 20, 0, 1, 0, 21, 0); exp_dir(0, '0); exp_dir(1, '0);
    step(0, 0, 1, 20, 36'h77, 1, 0, 20, 0); exp_dir(1, {1'b1, 36'h77});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("drained", {1'b0, WIDTH'(qa1.size() + qb1.size() + qa2.size() + qb2.size() + dq.size())}, '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
